// File: rtl/mmac_pkg.sv
// Shared constants and FSM state type for the sequential matrix multiply-accumulate unit.
package mmac_pkg;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned ACC_W_DEF = 32;

  // Width of a flat row-major element index for the default matrix size.
  localparam int unsigned IDX_W = $clog2(N_DEF * N_DEF);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StCompute,
    StDrain
  } state_e;

endpackage

// File: rtl/mmac_dot.sv
// Combinational N-lane signed dot product with an optional accumulator addend.
module mmac_dot #(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic [N-1:0][DW-1:0]     a_row_i,
  input  logic [N-1:0][DW-1:0]     b_col_i,
  input  logic signed [ACC_W-1:0]  addend_i,
  input  logic                     add_en_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  always_comb begin
    sum_o = add_en_i ? addend_i : '0;
    // Products are sign-extended to the accumulator width; the sum wraps.
    for (int k = 0; k < N; k++) begin
      sum_o = sum_o + ACC_W'($signed(a_row_i[k]) * $signed(b_col_i[k]));
    end
  end

endmodule

// File: rtl/mmac_seq_unit.sv
// Sequential N x N signed matrix multiply(-accumulate): streams in A then B, computes one
// C element per cycle, then streams C out row-major. C persists between jobs.
module mmac_seq_unit
  import mmac_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             acc_mode,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     RcW    = $clog2(N);
  localparam logic [RcW-1:0] LastRc = RcW'(N - 1);

  state_e           state_q, state_d;
  logic [DW-1:0]    a_q [N][N];
  logic [DW-1:0]    a_d [N][N];
  logic [DW-1:0]    b_q [N][N];
  logic [DW-1:0]    b_d [N][N];
  logic [ACC_W-1:0] c_q [N][N];
  logic [ACC_W-1:0] c_d [N][N];
  logic [RcW-1:0]   row_q, row_d, col_q, col_d;
  logic             acc_mode_q, acc_mode_d;
  logic             done_q, done_d;

  logic [RcW-1:0]        row_nx, col_nx;
  logic                  last_col, last_elem;
  logic [N-1:0][DW-1:0]  dot_a, dot_b;
  logic signed [ACC_W-1:0] dot_sum;

  // Operand selection for the element at (row_q, col_q).
  always_comb begin
    for (int k = 0; k < N; k++) begin
      dot_a[k] = a_q[row_q][k];
      dot_b[k] = b_q[k][col_q];
    end
  end

  mmac_dot #(
    .N     (N),
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_dot (
    .a_row_i  (dot_a),
    .b_col_i  (dot_b),
    .addend_i (c_q[row_q][col_q]),
    .add_en_i (acc_mode_q),
    .sum_o    (dot_sum)
  );

  always_comb begin
    last_col  = (col_q == LastRc);
    last_elem = last_col && (row_q == LastRc);
    col_nx    = last_col ? '0 : col_q + RcW'(1);
    row_nx    = last_col ? (last_elem ? '0 : row_q + RcW'(1)) : row_q;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    row_d      = row_q;
    col_d      = col_q;
    acc_mode_d = acc_mode_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;

    unique case (state_q)
      StIdle: begin
        if (clear) begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              c_d[i][j] = '0;
            end
          end
        end else if (start) begin
          state_d    = StLoadA;
          acc_mode_d = acc_mode;
          row_d      = '0;
          col_d      = '0;
        end
      end
      StLoadA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d[row_q][col_q] = in_data;
          row_d = row_nx;
          col_d = col_nx;
          if (last_elem) state_d = StLoadB;
        end
      end
      StLoadB: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b_d[row_q][col_q] = in_data;
          row_d = row_nx;
          col_d = col_nx;
          if (last_elem) state_d = StCompute;
        end
      end
      StCompute: begin
        c_d[row_q][col_q] = dot_sum;
        row_d = row_nx;
        col_d = col_nx;
        if (last_elem) state_d = StDrain;
      end
      StDrain: begin
        out_valid = 1'b1;
        out_data  = c_q[row_q][col_q];
        if (out_ready) begin
          row_d = row_nx;
          col_d = col_nx;
          if (last_elem) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy = (state_q != StIdle);
    done = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      acc_mode_q <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          c_q[i][j] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      row_q      <= row_d;
      col_q      <= col_d;
      acc_mode_q <= acc_mode_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mmac_seq_unit.sv
// Self-checking bench for mmac_seq_unit: directed and random jobs against a matrix-level model.
module tb_mmac_seq_unit;

  localparam int N  = 4;
  localparam int NN = N * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        acc_mode = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  mmac_seq_unit #(
    .N     (4),
    .DW    (8),
    .ACC_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .acc_mode  (acc_mode),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  total = 0;
  int  bad = 0;
  byte ja [NN];
  byte jb [NN];
  int  jexp [NN];
  int  c_model [NN];
  int  first_valid_lat;
  int  done_lat;

  // Matrix-level reference: C = A*B (+ C_old), 32-bit wrapping int arithmetic.
  task automatic build_exp(input bit acc);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s;
        s = acc ? c_model[i*N+j] : 0;
        for (int k = 0; k < N; k++) s += int'(ja[i*N+k]) * int'(jb[k*N+j]);
        jexp[i*N+j] = s;
      end
    end
    for (int x = 0; x < NN; x++) c_model[x] = jexp[x];
  endtask

  task automatic zero_model();
    for (int x = 0; x < NN; x++) c_model[x] = 0;
  endtask

  task automatic load_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ja[i*N+j] = (i == j) ? 8'sd1 : 8'sd0;
        jb[i*N+j] = byte'(i*N + j + 1);
      end
  endtask

  task automatic run_job(input bit acc, input bit bp, input string tag);
    int ai, oi, budget, c0;
    bit prev_stall;
    logic [31:0] prev_data;
    ai = 0; oi = 0; prev_stall = 0; prev_data = '0;
    build_exp(acc);
    @(negedge clk);
    start = 1'b1; acc_mode = acc; c0 = cyc;
    first_valid_lat = -1; done_lat = -1;
    @(negedge clk);
    start = 1'b0;
    budget = 0;
    while (ai < 2*NN && budget < 2000) begin
      in_valid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = (ai < NN) ? ja[ai] : jb[(ai < NN) ? 0 : ai - NN];
      if (in_valid && in_ready) ai++;
      budget++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (ai != 2*NN) begin
      bad++; $display("FAIL %s load_beats: got %0d want %0d", tag, ai, 2*NN);
    end
    budget = 0;
    while (oi < NN && budget < 2000) begin
      out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (out_valid) begin
        if (first_valid_lat < 0) first_valid_lat = cyc - c0;
        if (prev_stall) begin
          total++;
          if (out_data !== prev_data) begin
            bad++; $display("FAIL %s stall_hold[%0d]: got %h want %h", tag, oi, out_data, prev_data);
          end
        end
        if (out_ready) begin
          total++;
          if (out_data !== jexp[oi]) begin
            bad++; $display("FAIL %s out[%0d]: got %h want %h", tag, oi, out_data, jexp[oi]);
          end
          oi++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_data  = out_data;
        end
      end
      budget++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    total++;
    if (oi != NN) begin
      bad++; $display("FAIL %s out_beats: got %0d want %0d", tag, oi, NN);
    end
    done_lat = cyc - c0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL %s done_pulse: done=%b busy=%b want done=1 busy=0", tag, done, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL %s done_single: done=%b want 0", tag, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; clear = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
    total++;
    if (out_data !== 32'h0) begin bad++; $display("FAIL reset out_data: got %h want 0", out_data); end
    rst = 1'b0; start = 1'b0;
    zero_model();
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset idle_after: busy=%b want 0", busy); end
  endtask

  task automatic test_identity();
    load_identity();
    run_job(1'b0, 1'b0, "identity");
    total++;
    if (first_valid_lat != 3*NN + 1) begin
      bad++; $display("FAIL latency first_valid: got %0d want %0d", first_valid_lat, 3*NN + 1);
    end
    total++;
    if (done_lat != 4*NN + 1) begin
      bad++; $display("FAIL latency done: got %0d want %0d", done_lat, 4*NN + 1);
    end
  endtask

  task automatic test_signed();
    for (int x = 0; x < NN; x++) begin ja[x] = -8'sd1; jb[x] = 8'sd2; end
    run_job(1'b0, 1'b0, "signed");
  endtask

  task automatic test_accumulate();
    load_identity();
    run_job(1'b0, 1'b0, "acc_first");
    run_job(1'b1, 1'b0, "acc_second");
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    zero_model();
    run_job(1'b1, 1'b0, "acc_after_clear");
  endtask

  task automatic test_backpressure();
    load_identity();
    run_job(1'b0, 1'b1, "backpressure");
  endtask

  task automatic test_reset_mid_load();
    int ai;
    load_identity();
    @(negedge clk); start = 1'b1; acc_mode = 1'b0;
    @(negedge clk); start = 1'b0;
    ai = 0;
    for (int g = 0; g < 200 && ai < NN + 5; g++) begin
      in_valid = 1'b1;
      in_data  = (ai < NN) ? ja[ai] : jb[(ai < NN) ? 0 : ai - NN];
      if (in_ready) ai++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL midreset state: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
    rst = 1'b0;
    zero_model();
    run_job(1'b1, 1'b0, "after_midreset");
  endtask

  task automatic test_start_clear();
    @(negedge clk); start = 1'b1; clear = 1'b1; acc_mode = 1'b1;
    @(negedge clk); start = 1'b0; clear = 1'b0;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL start_clear idle: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
    zero_model();
    load_identity();
    run_job(1'b1, 1'b0, "start_clear_job");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int x = 0; x < NN; x++) begin
        ja[x] = byte'($urandom_range(0, 255));
        jb[x] = byte'($urandom_range(0, 255));
      end
      run_job(1'($urandom_range(0, 1)), 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_signed();
    test_accumulate();
    test_backpressure();
    test_reset_mid_load();
    test_start_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmac_seq_unit.md
MMAC_SEQ_UNIT -- requirements
Module: mmac_seq_unit

Interface
REQ-001 Parameter N, default 4: square matrix dimension, N >= 2.
REQ-002 Parameter DW, default 8: signed element width of A and B.
REQ-003 Parameter ACC_W, default 32: signed result width; ACC_W >= 2*DW + clog2(N).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  begin a job; sampled only in IDLE.
REQ-007 acc_mode  in  1  sampled with start: 1 = C_new = A*B + C_old, 0 = C_new = A*B.
REQ-008 clear  in  1  zero the result bank; sampled only in IDLE.
REQ-009 in_valid / in_ready  in / out  1 / 1  operand stream handshake.
REQ-010 in_data  in  DW  operand element: A then B, each row-major.
REQ-011 out_valid / out_ready  out / in  1 / 1  result stream handshake.
REQ-012 out_data  out  ACC_W  result element C[i][j], row-major.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse on the cycle after the final result beat is accepted.

Function
REQ-015 FSM states: IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN.
REQ-016 IDLE -> LOAD_A when start=1 and clear=0; acc_mode is latched on that cycle.
REQ-017 IDLE with clear=1: every C element becomes 0 on the next edge, and start is ignored that cycle.
REQ-018 start and clear are ignored outside IDLE.
REQ-019 in_ready=1 only in LOAD_A and LOAD_B; a beat transfers when in_valid and in_ready are both 1.
REQ-020 LOAD_A accepts exactly N*N beats into A[i][j] (j fastest), then -> LOAD_B; LOAD_B likewise fills B, then -> COMPUTE.
REQ-021 in_valid low stalls loading indefinitely without corrupting the counters.
REQ-022 COMPUTE takes exactly N*N cycles; cycle t computes element (i=t/N, j=t%N) = sum over k of A[i][k]*B[k][j], plus C_old[i][j] if acc_mode, and writes it to C.
REQ-023 Arithmetic: each signed DW x DW product is 2*DW bits, sign-extended to ACC_W; the sum wraps modulo 2^ACC_W with no saturation.
REQ-024 COMPUTE -> DRAIN after element (N-1,N-1) is written; out_valid is first high on the next cycle.
REQ-025 DRAIN: out_valid=1 and out_data=C at the current index; the index advances only on out_valid and out_ready.
REQ-026 out_data and out_valid stay stable while out_ready=0.
REQ-027 Final beat accepted -> IDLE with done=1 for one cycle; C is retained for a later acc_mode job.
REQ-028 With no stalls, start at cycle 0 gives first out_valid at cycle 3*N*N+1 and done at cycle 4*N*N+1.

Reset
REQ-029 rst=1 in any state, including mid-job, forces IDLE on the next edge and clears the A, B and C banks, all counters and latched acc_mode.
REQ-030 During and after reset: in_ready, out_valid, busy and done are 0, and out_data is 0.
REQ-031 rst has priority over start, clear and all handshakes.

Structure
REQ-032 mmac_pkg holds the N/DW/ACC_W default constants, the FSM state enum typedef and the index-width constant clog2(N*N).
REQ-033 One combinational sub-module, mmac_dot (N-lane signed dot product plus optional addend), is instantiated once and used by COMPUTE.
REQ-034 A, B and C are register arrays; no memory macros are used.

Verification
REQ-035 Identity: N=4, acc_mode=0, A=I, B=1..16 -> out_data 1..16 in order, then done.
REQ-036 Signed: A all 8'hFF, B all 8'h02 -> all 16 outputs 32'hFFFFFFF8 (-8).
REQ-037 Accumulate: identity job, then the same job with acc_mode=1 -> second job outputs 2,4,...,32; after clear, a third acc_mode=1 job outputs 1..16.
REQ-038 Backpressure: random in_valid and out_ready gaps -> same result sequence as REQ-035; out_data holds stable during every stall.
REQ-039 Reset mid-LOAD_B after 5 B beats -> next cycle busy=0 and in_ready=0; a following REQ-035 job is correct with C_old=0.
REQ-040 start and clear in the same IDLE cycle -> FSM stays IDLE and C is zeroed; start on the next cycle begins a job normally.
